// File: rtl/expr_pkg.sv
// Shared definitions for the expression-result capture stage: widths, default
// MISR polynomial, FSM state encoding and the 90-to-32 bit fold.
package expr_pkg;

  localparam int Y_W   = 90;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  localparam logic [SIG_W-1:0] POLY_DEFAULT = 32'h04C11DB7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Zero-extend to three 32-bit slices and XOR them together.
  function automatic logic [SIG_W-1:0] fold_y(input logic [Y_W-1:0] y);
    logic [95:0] w;
    w = {6'd0, y};
    return w[31:0] ^ w[63:32] ^ w[95:64];
  endfunction

endpackage

// File: rtl/expr_fold_misr.sv
// Combinational fold of one result vector plus the Galois MISR next-state
// function; shared between the capture stage and any golden-model wrapper.
module expr_fold_misr
  import expr_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] next_sig
);

  logic [SIG_W-1:0] fold_s;
  logic [SIG_W-1:0] fb_s;

  assign fold_s = fold_y(y);

  // Feedback term is applied only when the shifted-out bit is set.
  always_comb begin
    fb_s = {SIG_W{1'b0}};
    if (sig[SIG_W-1]) begin
      fb_s = POLY;
    end else begin
      fb_s = {SIG_W{1'b0}};
    end
  end

  assign next_sig = {sig[SIG_W-2:0], 1'b0} ^ fb_s ^ fold_s;

endmodule

// File: rtl/expr_result_misr.sv
// Capture stage: accepts result vectors over valid/ready, compacts them into a
// MISR signature over a programmed vector count and reports done/pass.
module expr_result_misr
  import expr_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [SIG_W-1:0] seed,
  input  logic [SIG_W-1:0] expected,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  state_t           state_r;
  logic [SIG_W-1:0] sig_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] num_r;
  logic [SIG_W-1:0] next_sig_s;
  logic             accept_s;
  logic             start_ok_s;
  logic             last_s;

  expr_fold_misr #(.POLY(POLY)) u_fold (
    .sig      (sig_r),
    .y        (in_y),
    .next_sig (next_sig_s)
  );

  assign accept_s   = in_valid && (state_r == ST_RUN);
  assign start_ok_s = start && (state_r != ST_RUN);
  assign last_s     = ((cnt_r + 16'd1) == num_r);

  // Run control, signature compaction and vector counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sig_r   <= {SIG_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      num_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            sig_r   <= seed;
            cnt_r   <= {CNT_W{1'b0}};
            num_r   <= num_vectors;
            state_r <= (num_vectors == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            sig_r <= next_sig_s;
            cnt_r <= cnt_r + 16'd1;
            if (last_s) begin
              state_r <= ST_DONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_RUN);
  assign busy      = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);
  assign signature = sig_r;
  assign vec_count = cnt_r;
  // Kept combinational so a late change of expected is reflected immediately.
  assign pass      = done && (sig_r == expected);

endmodule

// File: tb/tb_expr_result_misr.sv
// Self-checking bench for expr_result_misr: directed table, random runs against
// a polynomial-arithmetic reference model, and a reset-mid-run sequence.
module tb_expr_result_misr;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vectors = 16'd0;
  logic [31:0] seed = 32'd0;
  logic [31:0] expected = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [89:0] in_y = 90'd0;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [15:0] vec_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [89:0] q_y[$];

  always #5 clk = ~clk;

  expr_result_misr dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .seed(seed), .expected(expected), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .vec_count(vec_count)
  );

  typedef struct {
    logic [31:0] seed;
    logic [15:0] num;
    logic [89:0] y0;
    logic [89:0] y1;
    logic [31:0] expv;
    logic [31:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each input bit lands on bit (i mod 32) of the folded word.
  function automatic logic [31:0] m_fold(input logic [89:0] y);
    logic [31:0] f = 32'd0;
    for (int i = 0; i < 90; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  // Multiply signature by x modulo the degree-32 polynomial, then add the fold.
  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [89:0] y);
    logic [32:0] t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, POLY};
    return t[31:0] ^ m_fold(y);
  endfunction

  function automatic logic [89:0] rand_y();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_start(input logic [31:0] s, input logic [15:0] n);
    @(negedge clk);
    seed = s; num_vectors = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds q_y; called at a negedge, returns at the negedge after the last accept.
  task automatic feed(input bit gaps);
    int idx = 0;
    int cycles = 0;
    bit will;
    while (idx < q_y.size() && cycles < 2000) begin
      chk("done_early", {63'd0, done}, 64'd0);
      if (gaps && $urandom_range(0, 2) == 0) in_valid = 1'b0;
      else begin in_valid = 1'b1; in_y = q_y[idx]; end
      will = in_valid && in_ready;
      @(negedge clk);
      cycles++;
      if (will) idx++;
    end
    in_valid = 1'b0;
    if (idx < q_y.size()) chk("feed_timeout", 64'(idx), 64'(q_y.size()));
  endtask

  task automatic chk_done(input string tag, input logic [31:0] es, input logic [15:0] n, input logic ep);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_sig"}, {32'd0, signature}, {32'd0, es});
    chk({tag, "_cnt"}, {48'd0, vec_count}, {48'd0, n});
    chk({tag, "_pass"}, {63'd0, pass}, {63'd0, ep});
  endtask

  vec_t tbl[6];

  initial begin
    logic [31:0] ms;
    logic [15:0] n;

    #12;
    chk("rst_sig", {32'd0, signature}, 64'd0);
    chk("rst_cnt", {48'd0, vec_count}, 64'd0);
    chk("rst_flags", {60'd0, busy, done, pass, in_ready}, 64'd0);
    rst_n = 1'b1;

    tbl[0] = '{32'h0, 16'd1, 90'd0, 90'd0, 32'h0, 32'h0, 1'b1};
    tbl[1] = '{32'h0, 16'd1, 90'd0, 90'd0, 32'h0, 32'h1, 1'b0};
    tbl[1].y0 = 90'd1 << 64;
    tbl[2] = '{32'h0, 16'd2, 90'd1, 90'd0, 32'h2, 32'h2, 1'b1};
    tbl[3] = '{32'h80000000, 16'd1, 90'd0, 90'd0, 32'h04C11DB7, 32'h04C11DB7, 1'b1};
    tbl[4] = '{32'h80000000, 16'd1, 90'd0, 90'd0, 32'h0, 32'h04C11DB7, 1'b0};
    tbl[5] = '{32'hDEADBEEF, 16'd0, 90'd0, 90'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};

    for (int i = 0; i < 6; i++) begin
      q_y.delete();
      if (tbl[i].num >= 16'd1) q_y.push_back(tbl[i].y0);
      if (tbl[i].num >= 16'd2) q_y.push_back(tbl[i].y1);
      expected = tbl[i].expv;
      do_start(tbl[i].seed, tbl[i].num);
      if (tbl[i].num != 16'd0) feed(1'b0);
      chk_done($sformatf("tbl%0d", i), tbl[i].exp_sig, tbl[i].num, tbl[i].exp_pass);
    end

    // expected changes while DONE; pass follows without a clock edge.
    expected = 32'h12345678;
    #1 chk("exp_chg_pass0", {63'd0, pass}, 64'd0);
    expected = 32'hDEADBEEF;
    #1 chk("exp_chg_pass1", {63'd0, pass}, 64'd1);

    for (int r = 0; r < 12; r++) begin
      ms = $urandom();
      n = 16'($urandom_range(1, 20));
      q_y.delete();
      do_start(ms, n);
      for (int k = 0; k < n; k++) begin
        q_y.push_back(rand_y());
        ms = m_step(ms, q_y[k]);
      end
      expected = (r % 3 == 0) ? ms ^ 32'h00010000 : ms;
      feed(1'b1);
      chk_done($sformatf("rnd%0d", r), ms, n, (r % 3 != 0));
    end

    // Mid-run start is ignored; reset after two accepts discards the run.
    ms = 32'hA5A5_0F0F;
    do_start(ms, 16'd4);
    q_y.delete();
    q_y.push_back(rand_y());
    feed(1'b1);
    ms = m_step(ms, q_y[0]);
    start = 1'b1; seed = 32'h0; num_vectors = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", {63'd0, busy}, 64'd1);
    chk("midstart_cnt", {48'd0, vec_count}, 64'd1);
    chk("midstart_sig", {32'd0, signature}, {32'd0, ms});
    q_y.delete();
    q_y.push_back(rand_y());
    feed(1'b1);
    chk("pre_rst_cnt", {48'd0, vec_count}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sig", {32'd0, signature}, 64'd0);
    chk("midrst_cnt", {48'd0, vec_count}, 64'd0);
    chk("midrst_flags", {60'd0, busy, done, pass, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {62'd0, busy, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
